// File: rtl/bc_adjust_if.sv
// Pixel stream bundle: qualifier plus 24-bit RGB, no backpressure.
interface bc_adjust_if;
   logic       valid;
   logic [7:0] r;
   logic [7:0] g;
   logic [7:0] b;

   modport master (output valid, r, g, b);
   modport slave  (input  valid, r, g, b);
endinterface

// File: rtl/bc_adjust.sv
// Brightness/contrast stage: frame-committed settings applied to an RGB stream
// through a 3-stage pipeline, one lane per colour channel.

// One colour channel: S1 centre+multiply, S2 shift+offset, S3 clamp/bypass.
module bc_lane (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        pix,
   input  logic [5:0]        gain,
   input  logic signed [7:0] offset,
   input  logic              bypass,
   output logic [7:0]        out
);
   logic signed [15:0] d, g, m, y;
   logic signed [15:0] m1, y2;
   logic signed [7:0]  off1;
   logic               byp1, byp2;
   logic [7:0]         raw1, raw2, clamped;

   // Datapath arithmetic; everything kept at 16 bits so no term can overflow.
   always_comb begin
      d = $signed({8'b0, pix}) - 16'sd128;
      g = $signed({10'b0, gain});
      m = d * g;
      y = (m1 >>> 4) + 16'sd128 + $signed({{8{off1[7]}}, off1});
      clamped = y2[7:0];
      if (y2 < 16'sd0)        clamped = 8'd0;
      else if (y2 > 16'sd255) clamped = 8'd255;
   end

   // Pipeline registers; settings and bypass ride along with the pixel from S1.
   always_ff @(posedge clk) begin
      if (rst) begin
         m1   <= '0;
         off1 <= '0;
         byp1 <= 1'b0;
         raw1 <= '0;
         y2   <= '0;
         byp2 <= 1'b0;
         raw2 <= '0;
         out  <= '0;
      end else begin
         m1   <= m;
         off1 <= offset;
         byp1 <= bypass;
         raw1 <= pix;
         y2   <= y;
         byp2 <= byp1;
         raw2 <= raw1;
         out  <= byp2 ? raw2 : clamped;
      end
   end
endmodule

module bc_adjust #(
   parameter int BSTEP    = 8,
   parameter int CSTEP    = 2,
   parameter int GAIN_RST = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              binc,
   input  logic              bdec,
   input  logic              cinc,
   input  logic              cdec,
   input  logic              frame_en,
   input  logic              bypass,
   bc_adjust_if.slave        pix_in,
   bc_adjust_if.master       pix_out,
   output logic [7:0]        bright_cur,
   output logic [5:0]        gain_cur
);
   localparam int NUM_LANES = 3;
   localparam int STAGES    = 3;

   logic signed [7:0]  bright_pend, bright_q, bright_nxt;
   logic [5:0]         gain_pend, gain_q, gain_nxt;
   logic signed [9:0]  b_sum;
   logic signed [7:0]  g_sum;
   logic [STAGES:1]    vld_pipe;
   logic [NUM_LANES-1:0][7:0] pix, res;

   // Pending-setting update with saturation; both pulses together cancel.
   always_comb begin
      b_sum = {{2{bright_pend[7]}}, bright_pend};
      if (binc && !bdec)      b_sum = b_sum + 10'(BSTEP);
      else if (bdec && !binc) b_sum = b_sum - 10'(BSTEP);
      bright_nxt = b_sum[7:0];
      if (b_sum > 10'sd127)        bright_nxt = 8'sh7f;
      else if (b_sum < -10'sd128)  bright_nxt = 8'sh80;

      g_sum = $signed({2'b00, gain_pend});
      if (cinc && !cdec)      g_sum = g_sum + 8'(CSTEP);
      else if (cdec && !cinc) g_sum = g_sum - 8'(CSTEP);
      gain_nxt = g_sum[5:0];
      if (g_sum < 8'sd0)       gain_nxt = 6'd0;
      else if (g_sum > 8'sd63) gain_nxt = 6'd63;
   end

   // Settings registers; commit copies the pre-update pending value so a pulse
   // coincident with frame_en waits for the next frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         bright_pend <= '0;
         bright_q    <= '0;
         gain_pend   <= 6'(GAIN_RST);
         gain_q      <= 6'(GAIN_RST);
      end else begin
         bright_pend <= bright_nxt;
         gain_pend   <= gain_nxt;
         if (frame_en) begin
            bright_q <= bright_pend;
            gain_q   <= gain_pend;
         end
      end
   end

   // Valid travels alongside the data; reset flushes in-flight pixels.
   always_ff @(posedge clk) begin
      if (rst) vld_pipe <= '0;
      else     vld_pipe <= {vld_pipe[STAGES-1:1], pix_in.valid};
   end

   assign pix = {pix_in.r, pix_in.g, pix_in.b};

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      bc_lane u_lane (
         .clk    (clk),
         .rst    (rst),
         .pix    (pix[i]),
         .gain   (gain_q),
         .offset (bright_q),
         .bypass (bypass),
         .out    (res[i])
      );
   end

   assign pix_out.valid = vld_pipe[STAGES];
   assign pix_out.r     = res[2];
   assign pix_out.g     = res[1];
   assign pix_out.b     = res[0];
   assign bright_cur    = bright_q;
   assign gain_cur      = gain_q;
endmodule

// File: tb/tb_bc_adjust.sv
// Directed bench for bc_adjust: hand-computed vectors plus settings/reset sequences.
module tb_bc_adjust;
   logic       clk = 1'b0;
   logic       rst, binc, bdec, cinc, cdec, frame_en, bypass;
   logic [7:0] bright_cur;
   logic [5:0] gain_cur;
   int         n_chk = 0;
   int         n_fail = 0;

   bc_adjust_if pin ();
   bc_adjust_if pout ();

   bc_adjust dut (
      .clk        (clk),
      .rst        (rst),
      .binc       (binc),
      .bdec       (bdec),
      .cinc       (cinc),
      .cdec       (cdec),
      .frame_en   (frame_en),
      .bypass     (bypass),
      .pix_in     (pin.slave),
      .pix_out    (pout.master),
      .bright_cur (bright_cur),
      .gain_cur   (gain_cur)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] r, g, b;
      logic       byp;
      logic [7:0] er, eg, eb;
   } vec_t;

   vec_t tbl[6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic pulse(input logic bi, input logic bd, input logic ci,
                        input logic cd, input logic fe);
      binc = bi; bdec = bd; cinc = ci; cdec = cd; frame_en = fe;
      tick();
      binc = 0; bdec = 0; cinc = 0; cdec = 0; frame_en = 0;
   endtask

   task automatic pulses(input int n, input logic bi, input logic bd,
                         input logic ci, input logic cd);
      for (int i = 0; i < n; i++) pulse(bi, bd, ci, cd, 1'b0);
   endtask

   // Single pixel with an empty pipeline: checks exact 3-cycle latency.
   task automatic send(input string nm, input logic [7:0] r, g, b, input logic byp,
                       input logic [7:0] er, eg, eb);
      pin.valid = 1; pin.r = r; pin.g = g; pin.b = b; bypass = byp;
      tick();
      pin.valid = 0; bypass = 0; pin.r = 8'h5a; pin.g = 8'ha5; pin.b = 8'h33;
      tick();
      chk({nm, " early_valid"}, int'(pout.valid), 0);
      tick();
      chk({nm, " valid"}, int'(pout.valid), 1);
      chk({nm, " r"}, int'(pout.r), int'(er));
      chk({nm, " g"}, int'(pout.g), int'(eg));
      chk({nm, " b"}, int'(pout.b), int'(eb));
      tick();
   endtask

   task automatic chk_set(input string nm, input int eb, input int eg);
      chk({nm, " bright_cur"}, int'($signed(bright_cur)), eb);
      chk({nm, " gain_cur"}, int'(gain_cur), eg);
   endtask

   initial begin
      // gain 32, offset 0: y = (p-128)*2 + 128, clamped
      tbl[0] = '{8'd200, 8'd100, 8'd128, 1'b0, 8'd255, 8'd72,  8'd128};
      tbl[1] = '{8'd1,   8'd127, 8'd129, 1'b0, 8'd0,   8'd126, 8'd130};
      tbl[2] = '{8'd200, 8'd100, 8'd50,  1'b1, 8'd200, 8'd100, 8'd50};
      tbl[3] = '{8'd255, 8'd0,   8'd64,  1'b0, 8'd255, 8'd0,   8'd0};
      tbl[4] = '{8'd0,   8'd255, 8'd7,   1'b1, 8'd0,   8'd255, 8'd7};
      tbl[5] = '{8'd130, 8'd126, 8'd128, 1'b0, 8'd132, 8'd124, 8'd128};

      rst = 1; binc = 0; bdec = 0; cinc = 0; cdec = 0; frame_en = 0; bypass = 0;
      pin.valid = 0; pin.r = 0; pin.g = 0; pin.b = 0;
      tick(); tick();
      chk("reset out_valid", int'(pout.valid), 0);
      chk("reset out_r", int'(pout.r), 0);
      chk_set("reset", 0, 16);
      rst = 0;

      // 1: unity gain, zero offset
      send("t1", 8'd200, 8'd100, 8'd50, 1'b0, 8'd200, 8'd100, 8'd50);

      // 2: staged brightness
      pulse(1, 0, 0, 0, 0);
      send("t2 pre_commit", 8'd200, 8'd200, 8'd200, 1'b0, 8'd200, 8'd200, 8'd200);
      chk_set("t2 pre_commit", 0, 16);
      pulse(0, 0, 0, 0, 1);
      chk_set("t2 commit", 8, 16);
      send("t2 post_commit", 8'd200, 8'd200, 8'd200, 1'b0, 8'd208, 8'd208, 8'd208);

      // 3: offset saturation both ways
      pulses(20, 1, 0, 0, 0);
      pulse(0, 0, 0, 0, 1);
      chk_set("t3 sat_hi", 127, 16);
      send("t3 hi", 8'd250, 8'd250, 8'd250, 1'b0, 8'd255, 8'd255, 8'd255);
      pulses(40, 0, 1, 0, 0);
      pulse(0, 0, 0, 0, 1);
      chk_set("t3 sat_lo", -128, 16);
      send("t3 lo", 8'd10, 8'd10, 8'd10, 1'b0, 8'd0, 8'd0, 8'd0);

      // 4: gain 32, offset back to 0, back-to-back table stream
      pulses(16, 1, 0, 0, 0);
      pulses(8, 0, 0, 1, 0);
      pulse(0, 0, 0, 0, 1);
      chk_set("t4 commit", 0, 32);
      for (int i = 0; i < 8; i++) begin
         if (i < 6) begin
            pin.valid = 1; pin.r = tbl[i].r; pin.g = tbl[i].g; pin.b = tbl[i].b;
            bypass = tbl[i].byp;
         end else begin
            pin.valid = 0; bypass = 0;
         end
         tick();
         if (i >= 2) begin
            chk($sformatf("tbl%0d valid", i - 2), int'(pout.valid), 1);
            chk($sformatf("tbl%0d r", i - 2), int'(pout.r), int'(tbl[i-2].er));
            chk($sformatf("tbl%0d g", i - 2), int'(pout.g), int'(tbl[i-2].eg));
            chk($sformatf("tbl%0d b", i - 2), int'(pout.b), int'(tbl[i-2].eb));
         end
      end
      tick();
      chk("tbl drained", int'(pout.valid), 0);

      // 5: cancelling pulses, then pulse coincident with commit
      pulse(1, 1, 0, 0, 0);
      pulse(0, 0, 0, 0, 1);
      chk_set("t5 cancel", 0, 32);
      pulse(1, 0, 0, 0, 1);
      chk_set("t5 coincident", 0, 32);
      pulse(0, 0, 0, 0, 1);
      chk_set("t5 next_frame", 8, 32);

      // 6: bypass with gain 32 / offset 8, then reset mid-stream
      send("t6 bypass", 8'd200, 8'd100, 8'd50, 1'b1, 8'd200, 8'd100, 8'd50);
      send("t6 active", 8'd100, 8'd128, 8'd0, 1'b0, 8'd80, 8'd136, 8'd0);
      pin.valid = 1; pin.r = 8'd100; pin.g = 8'd100; pin.b = 8'd100;
      tick(); tick(); tick();
      chk("t6 stream valid", int'(pout.valid), 1);
      rst = 1;
      tick();
      rst = 0; pin.valid = 0;
      chk("t6 rst out_valid", int'(pout.valid), 0);
      chk("t6 rst out_r", int'(pout.r), 0);
      chk("t6 rst out_g", int'(pout.g), 0);
      chk("t6 rst out_b", int'(pout.b), 0);
      chk_set("t6 rst", 0, 16);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("t6 flushed%0d", i), int'(pout.valid), 0);
      end
      send("t6 restart", 8'd200, 8'd100, 8'd50, 1'b0, 8'd200, 8'd100, 8'd50);

      // gain 0: every pixel collapses to clamp(128 + offset)
      pulses(3, 1, 0, 0, 0);
      pulses(20, 0, 0, 0, 1);
      pulse(0, 0, 0, 0, 1);
      chk_set("gain0", 24, 0);
      send("gain0", 8'd255, 8'd0, 8'd77, 1'b0, 8'd152, 8'd152, 8'd152);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
